// File: rtl/rv_pkg.sv
// Shared definitions for the fetch slice: data width, the NOP encoding and the fetch FSM states.
package rv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH
    } fetchStateT;

    function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a flush and an occupancy count.
// The head reads as zero while the FIFO is empty.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       pushData,
    input  logic                   pop,
    output logic [WIDTH-1:0]       headData,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rdPtr;
    logic [AW-1:0]    wrPtr;
    logic             empty;
    logic             full;
    logic             doPush;
    logic             doPop;

    always_comb begin
        empty    = (count == '0);
        full     = (count == FullCount);
        doPush   = push && !full;
        doPop    = pop && !empty;
        headData = empty ? '0 : mem[rdPtr];
    end

    // Flush wins over a same-cycle push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
        end
    end

`ifndef SYNTHESIS
    overflowCheck: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !flush));
`endif

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issues in-order word requests, buffers responses and hands Instr + PC to decode.
// Optional INSTR_FETCH_MISALIGN_EN turns misaligned redirects into a flagged NOP entry.
module instr_fetch
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
`ifdef INSTR_FETCH_MISALIGN_EN
    output logic            instr_misalign,
`endif
    output logic [XLEN-1:0] instr_pc4
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0] DepthLimit = (CW+1)'(BUF_DEPTH);

    fetchStateT        state;
    fetchStateT        nextState;
    logic [XLEN-1:0]   fetchPc;
    logic [XLEN-1:0]   fetchPcNext;
    logic [XLEN-1:0]   targetPc;
    logic [XLEN-1:0]   rspPc;
    logic [CW-1:0]     dropCnt;
    logic [CW-1:0]     dropNext;
    logic [CW-1:0]     pcCount;
    logic [CW-1:0]     instrCount;
    logic [CW:0]       inUse;
    logic              redirectActive;
    logic              accept;
    logic              rspKeep;
    logic              misPush;
    logic              fetchStall;
    logic              instrPush;
    logic              instrPop;
    logic              instrEmpty;
    logic [2*XLEN-1:0] instrPushData;
    logic [2*XLEN-1:0] instrHead;

    // The shadow FIFO count is the number of requests still waiting for a response.
    fetch_fifo #(
        .WIDTH(XLEN),
        .DEPTH(BUF_DEPTH)
    ) pcShadow (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (1'b0),
        .push    (accept),
        .pushData(fetchPc),
        .pop     (imem_rsp_valid),
        .headData(rspPc),
        .count   (pcCount)
    );

    fetch_fifo #(
        .WIDTH(2*XLEN),
        .DEPTH(BUF_DEPTH)
    ) instrBuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (redirectActive),
        .push    (instrPush),
        .pushData(instrPushData),
        .pop     (instrPop),
        .headData(instrHead),
        .count   (instrCount)
    );

`ifdef INSTR_FETCH_MISALIGN_EN
    logic misStall;
    logic misPending;

    always_comb begin
        targetPc   = redirect_pc;
        misPush    = misPending && !redirectActive;
        fetchStall = misStall;
    end

    // A misaligned target parks fetch until the next redirect and queues one flagged NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misStall   <= 1'b0;
            misPending <= 1'b0;
        end else if (redirectActive) begin
            misStall   <= (redirect_pc[1:0] != 2'b00);
            misPending <= (redirect_pc[1:0] != 2'b00);
        end else if (misPush) begin
            misPending <= 1'b0;
        end
    end

    assign instr_misalign = instr_valid && (instr_pc[1:0] != 2'b00);
`else
    always_comb begin
        targetPc   = alignPc(redirect_pc);
        misPush    = 1'b0;
        fetchStall = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            BOOT:    nextState = RUN;
            RUN:     if (redirectActive && (pcCount - CW'(imem_rsp_valid)) != '0) nextState = FLUSH;
            FLUSH:   if (dropNext == '0) nextState = RUN;
            default: nextState = BOOT;
        endcase
    end

    always_comb begin
        inUse          = {1'b0, pcCount} + {1'b0, instrCount};
        imem_req_valid = (state == RUN) && (inUse < DepthLimit) && !redirect_valid && !fetchStall;
        instr_valid    = !instrEmpty && (state != FLUSH);
    end

    // Redirect discards this cycle's response too, so everything still in flight gets dropped.
    always_comb begin
        redirectActive = redirect_valid && (state != BOOT);
        accept         = imem_req_valid && imem_req_ready;
        rspKeep        = imem_rsp_valid && (dropCnt == '0) && !redirectActive;
        instrPush      = rspKeep || misPush;
        instrPushData  = misPush ? {fetchPc, NOP_INSTR} : {rspPc, imem_rsp_data};
        instrPop       = instr_valid && instr_ready;
        instrEmpty     = (instrCount == '0);

        dropNext = dropCnt;
        if (redirectActive) begin
            dropNext = pcCount - CW'(imem_rsp_valid);
        end else if (imem_rsp_valid && dropCnt != '0) begin
            dropNext = dropCnt - CW'(1);
        end

        fetchPcNext = fetchPc;
        if (redirectActive) begin
            fetchPcNext = targetPc;
        end else if (accept) begin
            fetchPcNext = fetchPc + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetchPc <= RESET_PC;
            dropCnt <= '0;
        end else begin
            fetchPc <= fetchPcNext;
            dropCnt <= dropNext;
        end
    end

    always_comb begin
        imem_addr = fetchPc;
        instr     = instrHead[XLEN-1:0];
        instr_pc  = instrHead[2*XLEN-1:XLEN];
        instr_pc4 = instrEmpty ? '0 : instrHead[2*XLEN-1:XLEN] + XLEN'(4);
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: cycle table after reset, then hand-written backpressure,
// redirect, wrap-around and misaligned-redirect sequences checked against an in-order PC scoreboard.
module tb_instr_fetch;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc4;
`ifdef INSTR_FETCH_MISALIGN_EN
    logic        instr_misalign;
`endif

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] expPc      = 32'h0;
    logic [31:0] memQ [$];

    typedef struct {
        logic        rdy;
        logic        rspEn;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expPc;
    } vecT;

    vecT vecs [8];

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .BUF_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
`ifdef INSTR_FETCH_MISALIGN_EN
        .instr_misalign(instr_misalign),
`endif
        .instr_pc4     (instr_pc4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0020_2223;
            32'h4:   return 32'h01c0_0113;
            32'h8:   return 32'h0040_2103;
            32'hC:   return 32'h0220_8263;
            default: return ~a;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge: drive inputs, let the combinational outputs settle.
    task automatic applyStimulus(input logic rdy, input logic rspEn, input logic redir, input logic [31:0] rpc);
        instr_ready    = rdy;
        imem_req_ready = 1'b1;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (rspEn && memQ.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memWord(memQ.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
    endtask

    // Scoreboard each pop, record accepted requests for the memory model, advance one cycle.
    task automatic endCycle();
        logic        acc;
        logic [31:0] accAddr;
        acc     = imem_req_valid && imem_req_ready;
        accAddr = imem_addr;
        if (!redirect_valid && instr_valid && instr_ready) begin
            checkOutput("popPc", instr_pc, expPc);
            checkOutput("popInstr", instr, (expPc[1:0] != 2'b00) ? NOP_INSTR : memWord(expPc));
            checkOutput("popPc4", instr_pc4, expPc + 32'd4);
            expPc = expPc + 32'd4;
        end
        if (redirect_valid) begin
`ifdef INSTR_FETCH_MISALIGN_EN
            expPc = redirect_pc;
`else
            expPc = redirect_pc & ~32'h3;
`endif
        end
        @(posedge clk);
        if (acc) memQ.push_back(accAddr);
        @(negedge clk);
    endtask

    task automatic runCycles(input int n, input logic rdy, input logic rspEn);
        for (int i = 0; i < n; i++) begin
            applyStimulus(rdy, rspEn, 1'b0, 32'h0);
            endCycle();
        end
    endtask

    task automatic waitReq(input int maxCyc, output bit found);
        found = 1'b0;
        for (int i = 0; i < maxCyc; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            if (imem_req_valid) begin
                found = 1'b1;
                break;
            end
            endCycle();
        end
        if (!found) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL waitReq: no request within %0d cycles", maxCyc);
        end
    endtask

    initial begin
        bit found;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h08, 1'b1, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h4};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h8};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC};

        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b1;
        #2;
        checkOutput("rstReqValid", 32'(imem_req_valid), 32'h0);
        checkOutput("rstAddr", imem_addr, 32'h0);
        checkOutput("rstInstrValid", 32'(instr_valid), 32'h0);
        checkOutput("rstInstr", instr, 32'h0);
        checkOutput("rstPc", instr_pc, 32'h0);
        checkOutput("rstPc4", instr_pc4, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] startup sequence");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].rdy, vecs[i].rspEn, 1'b0, 32'h0);
            checkOutput($sformatf("vec%0d.reqValid", i), 32'(imem_req_valid), 32'(vecs[i].expReq));
            checkOutput($sformatf("vec%0d.addr", i), imem_addr, vecs[i].expAddr);
            checkOutput($sformatf("vec%0d.instrValid", i), 32'(instr_valid), 32'(vecs[i].expValid));
            if (vecs[i].expValid) begin
                checkOutput($sformatf("vec%0d.pc", i), instr_pc, vecs[i].expPc);
            end
            endCycle();
        end

        $display("[TB] decode backpressure");
        runCycles(9, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("stallReqValid", 32'(imem_req_valid), 32'h0);
        checkOutput("stallInstrValid", 32'(instr_valid), 32'h1);
        checkOutput("stallPc", instr_pc, 32'h10);
        endCycle();
        runCycles(12, 1'b1, 1'b1);

        $display("[TB] redirect with two outstanding");
        runCycles(5, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("fullReqValid", 32'(imem_req_valid), 32'h0);
        checkOutput("outstanding", 32'(memQ.size()), 32'h2);
        checkOutput("fullInstrValid", 32'(instr_valid), 32'h0);
        endCycle();
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0100);
        checkOutput("redirReqValid", 32'(imem_req_valid), 32'h0);
        endCycle();
        for (int i = 1; i <= 2; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            checkOutput($sformatf("flush%0d.reqValid", i), 32'(imem_req_valid), 32'h0);
            checkOutput($sformatf("flush%0d.instrValid", i), 32'(instr_valid), 32'h0);
            endCycle();
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("postFlushReqValid", 32'(imem_req_valid), 32'h1);
        checkOutput("postFlushAddr", imem_addr, 32'h0000_0100);
        endCycle();
        runCycles(8, 1'b1, 1'b1);

        $display("[TB] redirect with response and pop");
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            if (instr_valid && imem_rsp_valid) begin
                found          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = 32'h0000_0200;
                #1;
                endCycle();
                break;
            end
            endCycle();
        end
        if (found) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            checkOutput("rrpInstrValid", 32'(instr_valid), 32'h0);
            checkOutput("rrpReqValid", 32'(imem_req_valid), 32'h1);
            checkOutput("rrpAddr", imem_addr, 32'h0000_0200);
            endCycle();
        end else begin
            compared++;
            mismatched++;
            $display("[TB] FAIL rrpSetup: no cycle with response and pop, got none, expected one");
        end
        runCycles(6, 1'b1, 1'b1);

        $display("[TB] address wrap");
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        endCycle();
        waitReq(6, found);
        if (found) begin
            checkOutput("wrapAddrHi", imem_addr, 32'hFFFF_FFFC);
            endCycle();
        end
        waitReq(6, found);
        if (found) begin
            checkOutput("wrapAddrLo", imem_addr, 32'h0);
            endCycle();
        end
        runCycles(6, 1'b1, 1'b1);

        $display("[TB] misaligned redirect");
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0102);
        endCycle();
`ifdef INSTR_FETCH_MISALIGN_EN
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            if (instr_valid && !found) begin
                found = 1'b1;
                checkOutput("misFlag", 32'(instr_misalign), 32'h1);
                checkOutput("misPc", instr_pc, 32'h0000_0102);
                checkOutput("misInstr", instr, 32'h0000_0013);
            end
            endCycle();
        end
        if (!found) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL misEntry: got no entry, expected one flagged NOP");
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("misStallReq", 32'(imem_req_valid), 32'h0);
        checkOutput("misStallValid", 32'(instr_valid), 32'h0);
        endCycle();
`else
        waitReq(6, found);
        if (found) begin
            checkOutput("maskedAddr", imem_addr, 32'h0000_0100);
            endCycle();
        end
        runCycles(6, 1'b1, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
